// File: rtl/pcie_ss_axis_demux.sv
// Packet-routing AXI-S demux: the SOP beat's index field picks one of NUM_CH
// registered source ports; out-of-range packets are discarded and counted.
module pcie_ss_axis_demux #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SEL_LSB     = 0,
  parameter int unsigned SEL_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned DROP_CNT_W  = 16,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_sink_tvalid,
  input  logic [TDATA_WIDTH-1:0]                   i_sink_tdata,
  input  logic [TDATA_WIDTH/8-1:0]                 i_sink_tkeep,
  input  logic                                     i_sink_tlast,
  input  logic [TUSER_WIDTH-1:0]                   i_sink_tuser_vendor,
  output logic                                     o_sink_tready_c,
  output logic [NUM_CH-1:0]                        o_src_tvalid,
  output logic [NUM_CH-1:0][TDATA_WIDTH-1:0]       o_src_tdata,
  output logic [NUM_CH-1:0][TDATA_WIDTH/8-1:0]     o_src_tkeep,
  output logic [NUM_CH-1:0]                        o_src_tlast,
  output logic [NUM_CH-1:0][TUSER_WIDTH-1:0]       o_src_tuser_vendor,
  input  logic [NUM_CH-1:0]                        i_src_tready,
  output logic [DROP_CNT_W-1:0]                    drop_count
);

  localparam int unsigned KEEP_W = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_SOP, ST_FWD, ST_DROP} state_e;

  state_e                            r_state;
  state_e                            w_state_nxt;
  logic [SEL_WIDTH-1:0]              w_idx;
  logic [SEL_WIDTH-1:0]              w_dest;
  logic [SEL_WIDTH-1:0]              r_dest;
  logic                              w_in_range;
  logic                              w_dest_rdy;
  logic                              w_accept;
  logic                              w_sop_accept;
  logic                              w_drop_sop;
  logic [NUM_CH-1:0]                 w_out_ready;
  logic [NUM_CH-1:0]                 w_route;
  logic [NUM_CH-1:0]                 r_tvalid;
  logic [NUM_CH-1:0]                 r_tlast;
  logic [NUM_CH-1:0][TDATA_WIDTH-1:0] r_tdata;
  logic [NUM_CH-1:0][KEEP_W-1:0]     r_tkeep;
  logic [NUM_CH-1:0][TUSER_WIDTH-1:0] r_tuser;
  logic [DROP_CNT_W-1:0]             r_drop_count;

  assign w_idx       = i_sink_tdata[SEL_LSB +: SEL_WIDTH];
  assign w_out_ready = ~r_tvalid | i_src_tready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SOP;
    else        r_state <= w_state_nxt;
  end

  // Next-state: only the SOP beat decides between forwarding and dropping
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SOP:  if (w_accept && !i_sink_tlast) w_state_nxt = w_in_range ? ST_FWD : ST_DROP;
      ST_FWD,
      ST_DROP: if (w_accept && i_sink_tlast) w_state_nxt = ST_SOP;
      default: w_state_nxt = ST_SOP;
    endcase
  end

  // Routing and handshake: tready follows the destination register's free slot
  always_comb begin
    w_dest          = r_dest;
    w_in_range      = 1'b0;
    w_dest_rdy      = 1'b0;
    o_sink_tready_c = 1'b1;
    w_route         = '0;
    case (r_state)
      ST_SOP: begin
        w_dest     = w_idx;
        w_in_range = (32'(w_idx) < NUM_CH);
      end
      ST_FWD:  w_in_range = 1'b1;
      default: w_in_range = 1'b0;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_dest == SEL_WIDTH'(c)) w_dest_rdy = w_out_ready[c];
    end
    if (w_in_range) o_sink_tready_c = w_dest_rdy;
    w_accept     = i_sink_tvalid & o_sink_tready_c;
    w_sop_accept = w_accept & (r_state == ST_SOP);
    w_drop_sop   = w_sop_accept & ~w_in_range;
    for (int c = 0; c < NUM_CH; c++) begin
      w_route[c] = w_accept & w_in_range & (w_dest == SEL_WIDTH'(c));
    end
  end

  // Destination latch and saturating packet-drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest       <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_sop_accept && w_in_range) r_dest <= w_idx;
      if (w_drop_sop && (r_drop_count != '1)) r_drop_count <= r_drop_count + DROP_CNT_W'(1);
    end
  end

  // Per-channel valid: reloads whenever the slot is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_out_ready[c]) r_tvalid[c] <= w_route[c];
      end
    end
  end

  // Per-channel payload registers, deliberately unreset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_out_ready[c] && w_route[c]) begin
        r_tdata[c] <= i_sink_tdata;
        r_tkeep[c] <= i_sink_tkeep;
        r_tlast[c] <= i_sink_tlast;
        r_tuser[c] <= i_sink_tuser_vendor;
      end
    end
  end

  assign o_src_tvalid       = r_tvalid;
  assign o_src_tdata        = r_tdata;
  assign o_src_tkeep        = r_tkeep;
  assign o_src_tlast        = r_tlast;
  assign o_src_tuser_vendor = r_tuser;
  assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_pcie_ss_axis_demux.sv
// Bench for pcie_ss_axis_demux: directed scenarios plus randomized traffic
// checked against per-channel expected-beat queues built at packet level.
module tb_pcie_ss_axis_demux;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned KW  = DW / 8;
  localparam int unsigned UW  = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     sink_tvalid;
  logic [DW-1:0]            sink_tdata;
  logic [KW-1:0]            sink_tkeep;
  logic                     sink_tlast;
  logic [UW-1:0]            sink_tuser;
  logic                     sink_tready;
  logic [NCH-1:0]           src_tvalid;
  logic [NCH-1:0][DW-1:0]   src_tdata;
  logic [NCH-1:0][KW-1:0]   src_tkeep;
  logic [NCH-1:0]           src_tlast;
  logic [NCH-1:0][UW-1:0]   src_tuser;
  logic [NCH-1:0]           src_tready;
  logic [CW-1:0]            drop_count;

  pcie_ss_axis_demux #(
    .NUM_CH(NCH), .SEL_LSB(0), .SEL_WIDTH(SW), .DROP_CNT_W(CW),
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sink_tvalid(sink_tvalid), .i_sink_tdata(sink_tdata), .i_sink_tkeep(sink_tkeep),
    .i_sink_tlast(sink_tlast), .i_sink_tuser_vendor(sink_tuser), .o_sink_tready_c(sink_tready),
    .o_src_tvalid(src_tvalid), .o_src_tdata(src_tdata), .o_src_tkeep(src_tkeep),
    .o_src_tlast(src_tlast), .o_src_tuser_vendor(src_tuser), .i_src_tready(src_tready),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    int            dest;
  } beat_t;

  beat_t       in_q[$];
  logic [63:0] exp_q[NCH][$];
  int          exp_drops = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic [DW-1:0] d, logic [KW-1:0] k, logic l, logic [UW-1:0] u);
    return 64'({u, l, k, d});
  endfunction

  function automatic logic [63:0] obs(int c);
    return pk(src_tdata[c], src_tkeep[c], src_tlast[c], src_tuser[c]);
  endfunction

  function automatic int pending();
    int n = in_q.size();
    for (int c = 0; c < NCH; c++) n += exp_q[c].size();
    return n;
  endfunction

  function automatic logic [63:0] sat_drops();
    return (exp_drops > 3) ? 64'd3 : 64'(exp_drops);
  endfunction

  // A packet routed to idx lands, beat for beat, on that channel's queue
  task automatic add_pkt(input int idx, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      if (i == 0) b.data[SW-1:0] = SW'(idx);
      b.keep = KW'($urandom);
      b.last = (i == len - 1);
      b.user = UW'($urandom);
      b.dest = (idx < int'(NCH)) ? idx : -1;
      in_q.push_back(b);
      if (idx < int'(NCH)) exp_q[idx].push_back(pk(b.data, b.keep, b.last, b.user));
    end
    if (idx >= int'(NCH)) exp_drops++;
  endtask

  task automatic drive_head(input bit valid);
    if (valid && in_q.size() > 0) begin
      sink_tvalid = 1'b1;
      sink_tdata  = in_q[0].data;
      sink_tkeep  = in_q[0].keep;
      sink_tlast  = in_q[0].last;
      sink_tuser  = in_q[0].user;
    end else begin
      sink_tvalid = 1'b0;
      sink_tdata  = $urandom;
      sink_tkeep  = KW'($urandom);
      sink_tlast  = 1'($urandom);
      sink_tuser  = UW'($urandom);
    end
  endtask

  // Random handshake engine; entered and left at posedge+1
  task automatic run(input int vld_pct, input int rdy_pct, input int max_cyc);
    logic [63:0]    held[NCH];
    logic [NCH-1:0] was_held;
    int             cyc;
    int             d;
    was_held = '0;
    cyc = 0;
    while (pending() > 0 && cyc < max_cyc) begin
      drive_head(int'($urandom_range(99)) < vld_pct);
      for (int c = 0; c < NCH; c++) src_tready[c] = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (was_held[c]) begin
          check($sformatf("hold_vld_ch%0d", c), 64'(src_tvalid[c]), 64'd1);
          check($sformatf("hold_data_ch%0d", c), obs(c), held[c]);
        end
        if (src_tvalid[c] && src_tready[c]) begin
          if (exp_q[c].size() == 0) check($sformatf("unexpected_beat_ch%0d", c), 64'd0, 64'd1);
          else check($sformatf("data_ch%0d", c), obs(c), exp_q[c].pop_front());
        end
        was_held[c] = src_tvalid[c] & ~src_tready[c];
        held[c]     = obs(c);
      end
      if (sink_tvalid && in_q[0].dest < 0) check("drop_tready", 64'(sink_tready), 64'd1);
      if (sink_tvalid && sink_tready) begin
        d = in_q[0].dest;
        if (d >= 0) check("no_overrun", 64'(src_tvalid[d] & ~src_tready[d]), 64'd0);
        void'(in_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    sink_tvalid = 1'b0;
    check("drained", 64'(pending()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    src_tready = '1;
    drive_head(1'b0);
    #12;
    check("rst_tvalid", 64'(src_tvalid), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Route: 3-beat packet to ch1, one-cycle latency, ch0/ch2 untouched
    add_pkt(1, 3);
    for (int k = 0; k < 3; k++) begin
      drive_head(1'b1);
      #1;
      check("route_tready", 64'(sink_tready), 64'd1);
      @(posedge clk);
      #1;
      void'(in_q.pop_front());
      check("route_vld", 64'(src_tvalid), 64'b010);
      check("route_data", obs(1), exp_q[1].pop_front());
    end
    drive_head(1'b0);
    @(posedge clk);
    #1;
    check("route_idle", 64'(src_tvalid), 64'd0);

    // Back-pressure: ch0 stalled mid-packet, one beat buffered, then released
    src_tready = 3'b110;
    add_pkt(0, 4);
    drive_head(1'b1);
    #1;
    check("bp_first_tready", 64'(sink_tready), 64'd1);
    @(posedge clk);
    #1;
    void'(in_q.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive_head(1'b1);
      #1;
      check("bp_tready", 64'(sink_tready), 64'd0);
      check("bp_held", obs(0), exp_q[0][0]);
      @(posedge clk);
      #1;
    end
    run(100, 100, 50);

    // Back-to-back single-beat packets alternating ch0/ch1 at full rate
    src_tready = '1;
    for (int k = 0; k < 6; k++) add_pkt(k % 2, 1);
    for (int k = 0; k < 6; k++) begin
      drive_head(1'b1);
      #1;
      check("b2b_tready", 64'(sink_tready), 64'd1);
      @(posedge clk);
      #1;
      void'(in_q.pop_front());
      check("b2b_vld", 64'(src_tvalid), 64'd1 << (k % 2));
      check("b2b_data", obs(k % 2), exp_q[k % 2].pop_front());
    end
    drive_head(1'b0);
    @(posedge clk);
    #1;

    // Drop: 4-beat idx=3 packet, then an idx=2 packet routes normally
    add_pkt(3, 4);
    for (int k = 0; k < 4; k++) begin
      drive_head(1'b1);
      #1;
      check("drop_tready", 64'(sink_tready), 64'd1);
      @(posedge clk);
      #1;
      void'(in_q.pop_front());
      check("drop_no_vld", 64'(src_tvalid), 64'd0);
    end
    check("drop_count1", 64'(drop_count), sat_drops());
    add_pkt(2, 2);
    run(100, 100, 20);

    // Saturation: four more drops takes the 2-bit counter past all-ones
    for (int k = 0; k < 4; k++) add_pkt(3, 1 + k % 3);
    run(100, 100, 40);
    check("drop_sat", 64'(drop_count), sat_drops());

    // Randomized mixed traffic
    for (int k = 0; k < 60; k++) add_pkt(int'($urandom_range(3)), 1 + int'($urandom_range(3)));
    run(70, 60, 3000);
    check("drop_rand", 64'(drop_count), sat_drops());

    // Async reset between beats 2 and 3 of a forwarded packet
    src_tready = '1;
    add_pkt(1, 3);
    for (int k = 0; k < 2; k++) begin
      drive_head(1'b1);
      @(posedge clk);
      #1;
      void'(in_q.pop_front());
    end
    check("pre_rst_vld", 64'(src_tvalid), 64'b010);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(src_tvalid), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    in_q.delete();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    exp_drops = 0;
    drive_head(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_pkt(0, 1);
    drive_head(1'b1);
    @(posedge clk);
    #1;
    void'(in_q.pop_front());
    check("post_rst_sop_vld", 64'(src_tvalid), 64'b001);
    check("post_rst_sop_data", obs(0), exp_q[0].pop_front());
    drive_head(1'b0);
    @(posedge clk);
    #1;

    add_pkt(3, 2);
    for (int k = 0; k < 12; k++) add_pkt(int'($urandom_range(3)), 1 + int'($urandom_range(4)));
    run(80, 50, 1000);
    check("drop_after_rst", 64'(drop_count), sat_drops());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pcie_ss_axis_demux.md
# pcie_ss_axis_demux

Packet-routing AXI-S demultiplexor for PCIe SS streams, the counterpart of the small AXI-S mux. It takes one pcie_ss_axis_if stream, decodes a channel index from the first beat of each packet, and forwards the whole packet to one of NUM_CH source ports through a single registered output stage per channel. Packets whose index is out of range are discarded and counted.

## Interface
- NUM_CH, 2, number of output channels (≥1).
- SEL_LSB, 0: LSB of the channel-index field in sink.tdata on the SOP beat.
- SEL_WIDTH, $clog2(NUM_CH) (min 1): width of the channel-index field.
- DROP_CNT_W, 16, width of drop_count.
- TDATA_WIDTH, ofs_pcie_ss_cfg_pkg::TDATA_WIDTH, data width.
- TUSER_WIDTH, ofs_pcie_ss_cfg_pkg::TUSER_WIDTH, tuser_vendor width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sink  pcie_ss_axis_if.sink  TDATA/TUSER  input packet stream.
- source[NUM_CH]  pcie_ss_axis_if.source  TDATA/TUSER  per-channel output streams.
- drop_count  output  DROP_CNT_W  count of dropped packets, saturating.

## Operation
- FSM states: SOP (expecting first beat), FWD (mid-packet, forwarding to latched dest), DROP (mid-packet, discarding).
- SOP: idx = sink.tdata[SEL_LSB +: SEL_WIDTH], decoded combinationally from the presented beat.
  - idx < NUM_CH: dest = idx; sink.tready = out_ready[idx]. On accept, write the beat into output register idx; if !tlast, latch dest and go to FWD.
  - idx ≥ NUM_CH: sink.tready = 1. On accept, increment drop_count (saturating at all-ones); if !tlast go to DROP; no output written.
- FWD: sink.tready = out_ready[dest_q]. Accepted beats go to output register dest_q; tlast accepted → SOP.
- DROP: sink.tready = 1; beats discarded; tlast accepted → SOP. drop_count counts packets, not beats.
- Per channel c: out_ready[c] = ~source[c].tvalid | source[c].tready. When out_ready[c] and a beat is routed to c, load tdata/tkeep/tlast/tuser_vendor and set tvalid = 1. When out_ready[c] with no beat routed to c, clear tvalid.
- Only one channel receives a beat per cycle. Packets are never interleaved on any output. A packet never splits across channels.
- The index field is examined only on the SOP beat. It is ignored on later beats.

## Timing
- Reset (async assert, sync release): state = SOP, every source[c].tvalid = 0, drop_count = 0. Data registers are not reset.
- Latency: a beat accepted at edge N appears on source[dest] starting the cycle after edge N (1-cycle latency).
- Throughput: 1 beat/cycle when the destination is not back-pressured, including back-to-back packets to different channels.
- sink.tready depends combinationally on source[dest].tready and source[dest].tvalid. It is never asserted toward a full register.
- A held output (tvalid & ~tready) keeps all fields stable until taken.
- Simultaneous events:
  - Same channel: in one cycle the consumer takes the old beat and the register loads the new one. tvalid stays 1.
  - Different channels: a stalled channel does not block other channels at SOP. It does block the current packet.
- Single-beat packet (tlast on SOP): stays in SOP. A drop of a single-beat packet increments drop_count once.
- Reset mid-packet: the FSM returns to SOP and outputs go invalid. Upstream is reset together, so no partial packet is resumed.
- drop_count at all-ones holds its value.

## Test plan
- Route: 3-beat packet, idx=1, NUM_CH=2 → beats appear on source[1] only, 1 cycle later, tlast on beat 3. source[0].tvalid stays 0.
- Back-pressure: hold source[0].tready=0 for 5 cycles mid-packet → sink.tready=0 after one beat is buffered. No data is lost or duplicated, and the order is preserved after release.
- Back-to-back channels: alternating single-beat packets to ch0/ch1 with both readys=1 → 1 beat/cycle and sink.tready constantly 1.
- Drop: NUM_CH=3, SEL_WIDTH=2, 4-beat packet with idx=3 → sink.tready=1 on every beat, no output tvalid, drop_count 0→1. A following idx=2 packet routes correctly.
- Saturation: DROP_CNT_W=2, five dropped packets → drop_count = 3.
- Async reset mid-FWD: assert rst_n=0 between beats 2 and 3 → all source tvalid = 0 immediately and drop_count = 0. After release, the next beat is decoded as SOP.
